// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - 32-bit LFSR stream checker with hunt/verify/lock synchronisation
// Optional error counter enabled by macro LFSR_CHECKER_ERRCNT_EN; without it err_count is tied to 0.
module lfsr_checker #(
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_word,
  input  logic        err_clr,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ref_word;
  logic [3:0]  match_cnt;
  logic [3:0]  miss_cnt;

  logic [31:0] pred;
  logic        hit;
  logic        verify_hit;
  logic [4:0]  match_inc;
  logic [4:0]  miss_inc;
  logic        lock_reached;
  logic        loss_reached;
  logic        locked_d;
  logic        err_d;

  // One step of the team's 32-bit generator: shift left, feedback from taps 30/28/24/23.
  function automatic logic [31:0] lfsr_next(input logic [31:0] w);
    return {w[30:0], w[30] ^ w[28] ^ w[24] ^ w[23]};
  endfunction

  // Prediction and counter arithmetic shared by the FSM and the datapath.
  always_comb begin
    pred         = lfsr_next(ref_word);
    hit          = (in_word == pred);
    verify_hit   = hit && (in_word != 32'd0);
    match_inc    = {1'b0, match_cnt} + 5'd1;
    miss_inc     = {1'b0, miss_cnt} + 5'd1;
    lock_reached = (match_inc == 5'(LOCK_THRESH));
    loss_reached = (miss_inc == 5'(LOSS_THRESH));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_nxt;
  end

  // Next-state logic; nothing moves on cycles without a valid word.
  always_comb begin
    state_nxt = state;
    if (in_valid) begin
      case (state)
        HUNT:    if (in_word != 32'd0) state_nxt = VERIFY;
        VERIFY:  if (verify_hit && lock_reached) state_nxt = LOCK;
        LOCK:    if (!hit && loss_reached) state_nxt = VERIFY;
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Output decode; registered below so outputs reflect the word sampled at the previous edge.
  always_comb begin
    locked_d = (state_nxt == LOCK);
    err_d    = in_valid && (state == LOCK) && !hit;
  end

  // Reference word and match/miss counters; in LOCK the reference flywheels on its own prediction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_word  <= 32'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
    end else if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_word != 32'd0) begin
            ref_word  <= in_word;
            match_cnt <= 4'd0;
          end
        end
        VERIFY: begin
          ref_word <= in_word;
          if (verify_hit) match_cnt <= match_inc[3:0];
          else            match_cnt <= 4'd0;
          if (verify_hit && lock_reached) miss_cnt <= 4'd0;
        end
        LOCK: begin
          if (hit) begin
            ref_word <= pred;
            miss_cnt <= 4'd0;
          end else if (loss_reached) begin
            ref_word  <= in_word;
            match_cnt <= 4'd0;
            miss_cnt  <= miss_inc[3:0];
          end else begin
            ref_word <= pred;
            miss_cnt <= miss_inc[3:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Registered lock flag and one-cycle error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      locked <= locked_d;
      err    <= err_d;
    end
  end

`ifdef LFSR_CHECKER_ERRCNT_EN
  logic [15:0] err_cnt_q;

  // Saturating error counter; a clear coinciding with an error leaves that error counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 16'd0;
    end else if (err_clr) begin
      err_cnt_q <= err_d ? 16'd1 : 16'd0;
    end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err_count      = 16'd0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - randomized self-checking bench for lfsr_checker against a behavioural model
module tb_lfsr_checker;

  localparam int LOCK_TH = 4;
  localparam int LOSS_TH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = 32'd0;
  logic        err_clr = 1'b0;
  logic        locked;
  logic        err;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  // behavioural model: phase 0 hunting, 1 verifying, 2 locked
  int          m_phase;
  logic [31:0] m_ref;
  int          m_match;
  int          m_miss;
  logic        m_err;
  int          m_cnt;
  logic [31:0] seq;

  lfsr_checker #(.LOCK_THRESH(LOCK_TH), .LOSS_THRESH(LOSS_TH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
    .err_clr(err_clr), .locked(locked), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // generator step computed arithmetically: double the word, append parity of taps 30/28/24/23
  function automatic logic [31:0] gen_step(input logic [31:0] w);
    logic [31:0] fb;
    fb = ((w >> 30) ^ (w >> 28) ^ (w >> 24) ^ (w >> 23)) & 32'd1;
    return (w * 2) + fb;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ref = 0; m_match = 0; m_miss = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] w, input logic c);
    logic [31:0] p;
    m_err = 0;
    if (v) begin
      if (m_phase == 0) begin
        if (w != 0) begin m_ref = w; m_match = 0; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (w == gen_step(m_ref) && w != 0) m_match++;
        else m_match = 0;
        m_ref = w;
        if (m_match == LOCK_TH) begin m_phase = 2; m_miss = 0; end
      end else begin
        p = gen_step(m_ref);
        if (w == p) begin
          m_miss = 0; m_ref = p;
        end else begin
          m_err = 1;
          m_miss++;
          if (m_miss == LOSS_TH) begin m_phase = 1; m_ref = w; m_match = 0; end
          else m_ref = p;
        end
      end
    end
`ifdef LFSR_CHECKER_ERRCNT_EN
    if (c) m_cnt = m_err ? 1 : 0;
    else if (m_err && m_cnt < 65535) m_cnt++;
`else
    if (c) m_cnt = 0;
`endif
  endtask

  // drive at the falling edge, check 1 ns after the rising edge
  task automatic send(input logic v, input logic [31:0] w, input logic c);
    in_valid = v; in_word = w; err_clr = c;
    @(posedge clk);
    model_step(v, w, c);
    #1;
    check("locked", locked, (m_phase == 2));
    check("err", err, m_err);
    check("err_count", err_count, m_cnt);
    @(negedge clk);
    in_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; err_clr = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // advance the reference stream and send its next word
  task automatic send_good();
    seq = gen_step(seq);
    send(1'b1, seq, 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    check("reset_locked", locked, 0);
    check("reset_err", err, 0);
    check("reset_count", err_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // seed-1 stream: lock from the cycle after the fifth word
    seq = 32'd1;
    send(1'b1, seq, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("prelock", locked, 0);
      send_good();
    end
    check("lock_after_5", locked, 1);

    // walk through the feedback point: 0x00400000 -> 0x00800000 -> 0x01000001
    while (seq != 32'h0040_0000 && checks < 5000) send_good();
    send_good();
    check("seq_800000", seq, 32'h0080_0000);
    send_good();
    check("seq_fb", seq, 32'h0100_0001);
    check("fb_no_err", err, 0);
    check("fb_locked", locked, 1);

    // single corrupted word: one pulse, lock held, next good word matches
    seq = gen_step(seq);
    send(1'b1, 32'hDEAD_BEEF, 1'b0);
    check("bad_pulse", err, 1);
    check("bad_locked", locked, 1);
    send_good();
    check("resume_no_err", err, 0);
`ifdef LFSR_CHECKER_ERRCNT_EN
    check("count_one", err_count, 1);
`endif

    // four wrong words drop lock; four successors of the last one relock
    for (int i = 0; i < 4; i++) begin
      logic [31:0] bad;
      seq = gen_step(seq);
      bad = seq ^ ($urandom | 32'd1);
      if (bad == 0) bad = 32'd7;
      send(1'b1, bad, 1'b0);
      check("loss_pulse", err, 1);
      if (i == 3) seq = bad;
    end
    check("loss_unlocked", locked, 0);
`ifdef LFSR_CHECKER_ERRCNT_EN
    check("count_five", err_count, 5);
`endif
    for (int i = 0; i < 4; i++) send_good();
    check("relock", locked, 1);

    // idle clear, then clear coinciding with an error
    send(1'b0, $urandom, 1'b1);
    check("clr_idle", err_count, 0);
    seq = gen_step(seq);
    send(1'b1, ~seq, 1'b1);
`ifdef LFSR_CHECKER_ERRCNT_EN
    check("clr_with_err", err_count, 1);
`endif
    check("clr_keeps_lock", locked, 1);

`ifdef LFSR_CHECKER_ERRCNT_EN
    // saturation
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFF;
    #1;
    release dut.err_cnt_q;
    m_cnt = 65535;
    seq = gen_step(seq);
    send(1'b1, ~seq, 1'b0);
    check("saturate", err_count, 16'hFFFF);
`endif

    // random traffic: gaps, occasional corruption, zeros and clears
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 3) send(1'b0, $urandom, (r == 0));
      else if (r == 3) begin seq = gen_step(seq); send(1'b1, $urandom, 1'b0); end
      else if (r == 4) begin seq = gen_step(seq); send(1'b1, 32'd0, 1'b0); end
      else if (r == 5) begin seq = $urandom | 32'd1; send(1'b1, seq, 1'b0); end
      else begin seq = gen_step(seq); send(1'b1, seq, (r == 6)); end
    end

    // all-zero stream never locks
    do_reset();
    for (int i = 0; i < 20; i++) send(1'b1, 32'd0, 1'b0);
    check("zeros_unlocked", locked, 0);

    // relock on a random seed, then asynchronous reset between edges
    seq = $urandom | 32'd1;
    send(1'b1, seq, 1'b0);
    for (int i = 0; i < 4; i++) send_good();
    check("rand_lock", locked, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_locked", locked, 0);
    check("async_count", err_count, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_good();
    check("reacq_start", locked, 0);
    for (int i = 0; i < 3; i++) send_good();
    check("reacq_partial", locked, 0);
    send_good();
    check("reacq_done", locked, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_THRESH, default 4, meaning the number of consecutive matching words needed to declare lock (legal range 1..15).
REQ-002 SHALL have parameter LOSS_THRESH, default 4, meaning the number of consecutive mismatching words in LOCKED needed to drop lock (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: in_word is sampled this cycle.
REQ-006 SHALL have port in_word, input, 32 bits: one received 32-bit LFSR generator register value per valid cycle.
REQ-007 SHALL have port err_clr, input, 1 bit: synchronous clear of err_count.
REQ-008 SHALL have port locked, output, 1 bit: checker is synchronised to the stream.
REQ-009 SHALL have port err, output, 1 bit: one-cycle pulse per mismatched word while LOCKED.
REQ-010 SHALL have port err_count, output, 16 bits: saturating count of mismatched words.

Function
REQ-011 SHALL define next(w) = {w[30:0], w[30]^w[28]^w[24]^w[23]}, bit-exact with the team's 32-bit generator step.
REQ-012 SHALL implement states HUNT, VERIFY and LOCKED, plus a 32-bit reference register ref, a match counter and a miss counter.
REQ-013 HUNT: on in_valid with in_word != 0, SHALL set ref <= in_word and match_cnt <= 0, then go to VERIFY; a zero word SHALL be ignored.
REQ-014 VERIFY: on in_valid, if in_word == next(ref) and in_word != 0, SHALL increment match_cnt; otherwise SHALL reset match_cnt to 0.
REQ-015 VERIFY: on in_valid, SHALL always set ref <= in_word.
REQ-016 VERIFY: when the incremented match_cnt equals LOCK_THRESH, SHALL go to LOCKED with miss_cnt <= 0.
REQ-017 LOCKED: on in_valid, SHALL set ref <= next(ref) regardless of in_word (flywheel), so a corrupted word does not corrupt the prediction.
REQ-018 LOCKED: on a mismatch (in_word != next(ref)), SHALL increment miss_cnt and pulse err on the following cycle.
REQ-019 LOCKED: on a match, SHALL set miss_cnt <= 0.
REQ-020 LOCKED: when the incremented miss_cnt equals LOSS_THRESH, SHALL go to VERIFY with ref <= in_word and match_cnt <= 0.
REQ-021 Cycles with in_valid=0 SHALL leave all state, ref and counters unchanged; err SHALL be 0 on those cycles.
REQ-022 locked, err and err_count SHALL be registered: they reflect the word sampled at edge N from edge N onward, i.e. visible in cycle N+1.
REQ-023 locked SHALL be 1 exactly when the state is LOCKED.
REQ-024 err_count SHALL increment on each mismatch in LOCKED and saturate at 0xFFFF without wrapping.
REQ-025 err_clr with no simultaneous error SHALL set err_count to 0.
REQ-026 err_clr simultaneous with an error SHALL set err_count to 1.
REQ-027 err_clr SHALL NOT affect the state, lock status or err.

Reset
REQ-028 rst=1 SHALL immediately force state HUNT, ref=0, match_cnt=0, miss_cnt=0, locked=0, err=0 and err_count=0, independent of clk.
REQ-029 Reset asserted mid-stream SHALL discard lock; after release, lock SHALL require a full reacquisition (1 capture word plus LOCK_THRESH matches).

Configuration
REQ-030 With macro LFSR_CHECKER_ERRCNT_EN defined, err_count and err_clr SHALL behave per REQ-024 to REQ-026.
REQ-031 Without LFSR_CHECKER_ERRCNT_EN, err_count SHALL be constant 0, err_clr SHALL be ignored, and no counter register SHALL be synthesised; all other behaviour SHALL be unchanged.

Verification
REQ-032 Default parameters, after reset, feed valid words 0x00000001, 0x00000002, 0x00000004, 0x00000008, 0x00000010 -> locked=1 from the cycle after the 5th word, err never 1.
REQ-033 Once locked on the seed-1 stream, feed 0x00400000 -> 0x00800000 -> 0x01000001 -> no error, confirming the feedback bit.
REQ-034 Once locked, replace one word with 0xDEADBEEF, then resume the correct sequence -> one err pulse, err_count=1, locked stays 1 and the next correct word matches.
REQ-035 Once locked, feed 4 consecutive wrong words -> 4 err pulses, locked=0 after the 4th, err_count=4; then 4 correct successors -> relock.
REQ-036 Feed all-zero words after reset -> locked stays 0 indefinitely.
REQ-037 Force err_count=0xFFFF and inject an error -> err_count stays 0xFFFF.
REQ-038 Assert err_clr on the same cycle as an error -> err_count=1.
REQ-039 Assert rst asynchronously mid-cycle while locked -> locked=0 before the next clk edge.
